// File: rtl/fifo_pkt_framer.sv
// fifo_pkt_framer: buffers words from a FWFT FIFO and emits them as a header flit plus payload flits,
// closing a packet when the buffer is full, on timeout, or on flush.
module fifo_pkt_framer #(
  parameter int DW      = 32,
  parameter int MAX_LEN = 8,
  parameter int TIMEOUT = 64,
  parameter int DEST    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          flush,
  output logic [DW-1:0] out_flit,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] ML = 16'(MAX_LEN);
  localparam logic [31:0] TL = 32'(TIMEOUT - 1);
  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;
  state_t state_q, state_d;
  logic [15:0] fill_q, fill_d, idx_q, idx_d;
  logic [31:0] timer_q, timer_d;
  logic [DW-1:0] mem_q [2**AW];
  logic collect, close, last;
  always_comb begin
    collect = state_q == COLLECT;
    close = collect && (fill_q == ML || (fill_q != 16'd0 && (timer_q == TL || flush)));
    fifo_rd_en = collect && !fifo_empty && fill_q < ML && !close;
    last = idx_q == fill_q - 16'd1;
    out_valid = !collect;
    out_last = state_q == PAYLOAD && last;
    busy = !collect || fill_q != 16'd0;
    out_flit = '0;
    if (state_q == HEADER) begin
      out_flit[DW-1 -: 8] = 8'(DEST);
      out_flit[15:0] = fill_q;
    end else if (state_q == PAYLOAD) begin
      out_flit = mem_q[idx_q[AW-1:0]];
    end
    state_d = close ? HEADER : state_q;
    fill_d = fifo_rd_en ? fill_q + 16'd1 : fill_q;
    timer_d = collect && fill_q != 16'd0 ? timer_q + 32'd1 : timer_q;
    idx_d = idx_q;
    if (state_q == HEADER && out_ready) begin
      state_d = PAYLOAD;
      idx_d = 16'd0;
    end
    // Final payload transfer empties the buffer and rearms collection.
    if (state_q == PAYLOAD && out_ready) begin
      state_d = last ? COLLECT : PAYLOAD;
      idx_d = last ? 16'd0 : idx_q + 16'd1;
      fill_d = last ? 16'd0 : fill_q;
      timer_d = last ? 32'd0 : timer_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      fill_q <= '0;
      idx_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
    end
  end
  always_ff @(posedge clk)
    if (fifo_rd_en) mem_q[fill_q[AW-1:0]] <= fifo_dout;
endmodule

// File: tb/tb_fifo_pkt_framer.sv
// tb_fifo_pkt_framer: directed tests of the packet framer (defaults) and a MAX_LEN=1/TIMEOUT=1 instance.
module tb_fifo_pkt_framer;
  localparam int TO = 64;
  logic clk = 0, rst = 1, flush = 0, out_ready = 0;
  logic [31:0] fifo_dout, out_flit;
  logic fifo_empty, fifo_rd_en, out_last, out_valid, busy;
  int tests = 0, fails = 0;

  logic [31:0] fm [64];
  int wp = 0, rp = 0;
  assign fifo_empty = wp == rp;
  assign fifo_dout = fm[rp[5:0]];
  always @(posedge clk) if (fifo_rd_en) rp <= rp + 1;

  logic [31:0] rx [256];
  logic rxl [256];
  int n = 0;
  always @(posedge clk) if (out_valid && out_ready) begin
    rx[n[7:0]] <= out_flit;
    rxl[n[7:0]] <= out_last;
    n <= n + 1;
  end

  fifo_pkt_framer dut (.clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_flit(out_flit), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  logic f1_en = 0, rd1, last1, valid1, busy1;
  logic [31:0] f1_data = 32'h100, flit1;
  always @(posedge clk) if (rd1) f1_data <= f1_data + 1;
  logic [31:0] rx1 [64];
  logic rxl1 [64];
  int n1 = 0;
  always @(posedge clk) if (valid1) begin
    rx1[n1[5:0]] <= flit1;
    rxl1[n1[5:0]] <= last1;
    n1 <= n1 + 1;
  end

  fifo_pkt_framer #(.MAX_LEN(1), .TIMEOUT(1)) u1 (.clk(clk), .rst(rst), .fifo_dout(f1_data),
    .fifo_empty(!f1_en), .fifo_rd_en(rd1), .flush(1'b0), .out_flit(flit1), .out_last(last1),
    .out_valid(valid1), .out_ready(1'b1), .busy(busy1));

  always #5 clk = ~clk;

  task cyc;
    @(negedge clk);
    #1;
  endtask

  task push(input logic [31:0] v);
    fm[wp[5:0]] = v;
    wp++;
  endtask

  task test_reset;
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    cyc();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", out_last); end
    tests++; if (out_flit !== 32'h0) begin fails++; $display("FAIL reset_flit: got %h expected 0", out_flit); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
  endtask

  task test_full;
    int base;
    base = n;
    out_ready = 1;
    for (int v = 1; v <= 8; v++) push(32'(v));
    #1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL full_pop%0d: got %b expected 1", i, fifo_rd_en); end
      cyc();
    end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL full_no_pop: got %b expected 0", fifo_rd_en); end
    for (int i = 0; i < 40 && n < base + 9; i++) cyc();
    tests++; if (n < base + 9) begin fails++; $display("FAIL full_timeout: got %0d flits expected 9", n - base); end
    tests++; if (rx[base[7:0]] !== 32'h8 || rxl[base[7:0]] !== 1'b0) begin fails++; $display("FAIL full_header: got %h/%b expected 00000008/0", rx[base[7:0]], rxl[base[7:0]]); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rx[8'(base + 1 + i)] !== 32'(i + 1) || rxl[8'(base + 1 + i)] !== (i == 7)) begin
        fails++; $display("FAIL full_payload%0d: got %h/%b expected %h/%b", i, rx[8'(base + 1 + i)], rxl[8'(base + 1 + i)], i + 1, i == 7);
      end
    end
  endtask

  task test_timeout;
    out_ready = 1;
    push(32'hA5);
    #1;
    tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL to_pop: got %b expected 1", fifo_rd_en); end
    for (int k = 1; k <= TO; k++) cyc();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL to_early: got %b expected 0", out_valid); end
    cyc();
    tests++; if (out_valid !== 1'b1 || out_flit !== 32'h1 || out_last !== 1'b0) begin fails++; $display("FAIL to_header: got %b/%h/%b expected 1/00000001/0", out_valid, out_flit, out_last); end
    cyc();
    tests++; if (out_valid !== 1'b1 || out_flit !== 32'hA5 || out_last !== 1'b1) begin fails++; $display("FAIL to_payload: got %b/%h/%b expected 1/000000a5/1", out_valid, out_flit, out_last); end
    cyc();
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL to_idle: got %b/%b expected 0/0", out_valid, busy); end
  endtask

  task test_flush;
    int base;
    base = n;
    out_ready = 1;
    push(32'h11); push(32'h12); push(32'h13);
    repeat (3) cyc();
    push(32'h14);
    flush = 1;
    #1;
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL flush_no_pop: got %b expected 0", fifo_rd_en); end
    cyc();
    flush = 0;
    for (int i = 0; i < 20 && n < base + 4; i++) cyc();
    tests++; if (n < base + 4) begin fails++; $display("FAIL flush_timeout: got %0d flits expected 4", n - base); end
    tests++; if (rx[base[7:0]] !== 32'h3) begin fails++; $display("FAIL flush_header: got %h expected 00000003", rx[base[7:0]]); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rx[8'(base + 1 + i)] !== 32'h11 + 32'(i) || rxl[8'(base + 1 + i)] !== (i == 2)) begin
        fails++; $display("FAIL flush_payload%0d: got %h/%b expected %h/%b", i, rx[8'(base + 1 + i)], rxl[8'(base + 1 + i)], 32'h11 + 32'(i), i == 2);
      end
    end
    repeat (2) cyc();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_next_busy: got %b expected 1", busy); end
    flush = 1;
    cyc();
    flush = 0;
    for (int i = 0; i < 20 && n < base + 6; i++) cyc();
    tests++; if (rx[8'(base + 4)] !== 32'h1 || rx[8'(base + 5)] !== 32'h14 || rxl[8'(base + 5)] !== 1'b1) begin
      fails++; $display("FAIL flush_next_pkt: got %h %h/%b expected 00000001 00000014/1", rx[8'(base + 4)], rx[8'(base + 5)], rxl[8'(base + 5)]);
    end
  endtask

  task test_stall;
    int base;
    logic pv, pl;
    logic [31:0] pf;
    base = n;
    out_ready = 1;
    for (int v = 0; v < 5; v++) push(32'h21 + 32'(v));
    repeat (6) cyc();
    flush = 1;
    pv = 0; pf = '0; pl = 0;
    for (int i = 0; i < 200 && n < base + 6; i++) begin
      cyc();
      flush = 0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (pv) begin
        tests++;
        if (out_valid !== 1'b1 || out_flit !== pf || out_last !== pl) begin
          fails++; $display("FAIL stall_hold: got %b/%h/%b expected 1/%h/%b", out_valid, out_flit, out_last, pf, pl);
        end
      end
      pv = out_valid && !out_ready;
      pf = out_flit;
      pl = out_last;
    end
    out_ready = 1;
    cyc();
    tests++; if (n < base + 6) begin fails++; $display("FAIL stall_timeout: got %0d flits expected 6", n - base); end
    tests++; if (rx[base[7:0]] !== 32'h5) begin fails++; $display("FAIL stall_header: got %h expected 00000005", rx[base[7:0]]); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rx[8'(base + 1 + i)] !== 32'h21 + 32'(i) || rxl[8'(base + 1 + i)] !== (i == 4)) begin
        fails++; $display("FAIL stall_payload%0d: got %h/%b expected %h/%b", i, rx[8'(base + 1 + i)], rxl[8'(base + 1 + i)], 32'h21 + 32'(i), i == 4);
      end
    end
  endtask

  task test_reset_mid;
    int base;
    logic found;
    out_ready = 1;
    for (int v = 0; v < 4; v++) push(32'h31 + 32'(v));
    repeat (5) cyc();
    flush = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      flush = 0;
      if (out_valid && out_flit == 32'h33) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL rmid_reach_idx2: got %b expected 1", found); end
    rst = 1;
    cyc();
    rst = 0;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_idle: got %b/%b expected 0/0", out_valid, busy); end
    base = n;
    push(32'h41); push(32'h42);
    repeat (3) cyc();
    flush = 1;
    cyc();
    flush = 0;
    for (int i = 0; i < 20 && n < base + 3; i++) cyc();
    tests++; if (n !== base + 3) begin fails++; $display("FAIL rmid_count: got %0d flits expected 3", n - base); end
    tests++; if (rx[base[7:0]] !== 32'h2 || rx[8'(base + 1)] !== 32'h41 || rx[8'(base + 2)] !== 32'h42 || rxl[8'(base + 2)] !== 1'b1) begin
      fails++; $display("FAIL rmid_pkt: got %h %h %h expected 00000002 00000041 00000042", rx[base[7:0]], rx[8'(base + 1)], rx[8'(base + 2)]);
    end
  endtask

  task test_max1;
    f1_en = 1;
    repeat (30) cyc();
    f1_en = 0;
    repeat (4) cyc();
    tests++; if (n1 < 6) begin fails++; $display("FAIL max1_count: got %0d flits expected >=6", n1); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (rx1[6'(2 * k)] !== 32'h1 || rxl1[6'(2 * k)] !== 1'b0 || rx1[6'(2 * k + 1)] !== 32'h100 + 32'(k) || rxl1[6'(2 * k + 1)] !== 1'b1) begin
        fails++; $display("FAIL max1_pkt%0d: got %h/%b %h/%b expected 00000001/0 %h/1", k, rx1[6'(2 * k)], rxl1[6'(2 * k)], rx1[6'(2 * k + 1)], rxl1[6'(2 * k + 1)], 32'h100 + 32'(k));
      end
    end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL max1_idle: got %b expected 0", busy1); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_timeout();
    test_flush();
    test_stall();
    test_reset_mid();
    test_max1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
